// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite transfer/size/response encodings and the memory-slave state type
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00, HTRANS_BUSY = 2'b01, HTRANS_NONSEQ = 2'b10, HTRANS_SEQ = 2'b11;
  localparam logic [2:0] HSIZE_BYTE = 3'b000, HSIZE_HALF = 3'b001, HSIZE_WORD = 3'b010;
  localparam logic HRESP_OKAY = 1'b0, HRESP_ERROR = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} slv_state_t;
endpackage

// File: rtl/ahb_byte_lane_decode.sv
// ahb_byte_lane_decode: i_size/i_addr[1:0] -> o_lanes (little-endian byte enables), o_misaligned (misaligned or illegal size)
module ahb_byte_lane_decode
  import ahb_pkg::*;
(
  input  logic [2:0] i_size,
  input  logic [1:0] i_addr,
  output logic [3:0] o_lanes,
  output logic       o_misaligned
);
  always_comb begin
    o_lanes = i_size == HSIZE_BYTE ? 4'b0001 << i_addr :
              i_size == HSIZE_HALF ? (i_addr[1] ? 4'b1100 : 4'b0011) :
              i_size == HSIZE_WORD ? 4'b1111 : 4'b0000;
    o_misaligned = i_size == HSIZE_HALF ? i_addr[0] : i_size == HSIZE_WORD ? |i_addr : i_size > HSIZE_WORD;
  end
endmodule

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB slave word memory with WAIT_STATES wait cycles, byte-lane writes and two-cycle ERROR; ports Hclk/Hresetn, Hsel/Haddr/Hwrite/Htrans/Hsize/Hwdata/Hready in, Hrdata/Hready_out/Hresp out
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        Hsel,
  input  logic [31:0] Haddr,
  input  logic        Hwrite,
  input  logic [1:0]  Htrans,
  input  logic [2:0]  Hsize,
  input  logic [31:0] Hwdata,
  input  logic        Hready,
  output logic [31:0] Hrdata,
  output logic        Hready_out,
  output logic        Hresp
);
  localparam int IW = $clog2(MEM_DEPTH);
  slv_state_t r_state, w_next;
  logic [3:0] r_cnt, r_lanes, w_lanes;
  logic [IW-1:0] r_idx;
  logic r_write, w_misaligned, w_accept, w_illegal, w_unused;
  logic [31:0] r_mem [MEM_DEPTH];
  ahb_byte_lane_decode u_lanes (
    .i_size      (Hsize),
    .i_addr      (Haddr[1:0]),
    .o_lanes     (w_lanes),
    .o_misaligned(w_misaligned)
  );
  always_comb begin
    w_accept = Hsel && Hready && Htrans[1] && Hready_out;
    w_illegal = w_misaligned || 32'(Haddr[ADDR_WIDTH-1:0]) >= 32'(MEM_DEPTH * 4);
    w_unused = ^{Haddr[31:ADDR_WIDTH], Htrans[0]};
  end
  always_ff @(posedge Hclk) begin
    if (!Hresetn) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT:  w_next = r_cnt == 4'd0 ? S_DONE : S_WAIT;
      S_ERR1:  w_next = S_ERR2;
      default: w_next = !w_accept ? S_IDLE : w_illegal ? S_ERR1 : WAIT_STATES > 0 ? S_WAIT : S_DONE;
    endcase
  end
  always_comb begin
    Hready_out = !(r_state inside {S_WAIT, S_ERR1});
    Hresp = r_state inside {S_ERR1, S_ERR2} ? HRESP_ERROR : HRESP_OKAY;
    Hrdata = r_state == S_DONE && !r_write ? r_mem[r_idx] : '0;
  end
  always_ff @(posedge Hclk) begin
    if (w_accept) begin
      r_cnt <= 4'(WAIT_STATES - 1);
      r_idx <= Haddr[IW+1:2];
      r_write <= Hwrite;
      r_lanes <= w_lanes;
    end else if (r_state == S_WAIT) r_cnt <= r_cnt - 4'd1;
  end
  always_ff @(posedge Hclk) begin
    if (Hresetn && r_state == S_DONE && r_write)
      for (int b = 0; b < 4; b++)
        if (r_lanes[b]) r_mem[r_idx][8*b +: 8] <= Hwdata[8*b +: 8];
  end
endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
- AHB slave with on-chip word memory; the responder end of the bus.
- Sources one set of Hrdata/Hready_out/Hresp, which the slave-response multiplexer routes back to the master.
- Decodes address/control phase, inserts a configurable number of wait states and performs byte-lane writes.
- Returns the two-cycle ERROR response for illegal accesses.

Parameters:
- ADDR_WIDTH, 12, local offset bits decoded from Haddr (4 KB window).
- MEM_DEPTH, 256, number of 32-bit words implemented (1 KB). Offsets at or above MEM_DEPTH*4 return ERROR.
- WAIT_STATES, 1, data-phase cycles with Hready_out low before completion of an OKAY transfer (0..15).

Ports:
- Hclk  input  1  bus clock, rising edge.
- Hresetn  input  1  reset, active-low, synchronous to Hclk.
- Hsel  input  1  slave select from the address decoder.
- Haddr  input  32  transfer address; only [ADDR_WIDTH-1:0] is used.
- Hwrite  input  1  1 = write, 0 = read.
- Htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- Hsize  input  3  000 = byte, 001 = half, 010 = word; other values are illegal.
- Hwdata  input  32  write data, valid in the data phase.
- Hready  input  1  system ready (multiplexed Hready_out of the active slave).
- Hrdata  output  32  read data.
- Hready_out  output  1  this slave's ready.
- Hresp  output  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset: synchronous, Hresetn low sampled at a Hclk edge.
  - State returns to IDLE; any pending write is dropped.
  - Hready_out=1, Hresp=0, Hrdata=0.
  - Memory contents are not reset.
- Address phase accepted when Hsel && Hready && Htrans[1] at a rising edge.
  - Haddr offset, Hwrite and Hsize are captured into registers.
  - IDLE/BUSY or Hsel=0: nothing is captured; the slave stays IDLE with zero-wait OKAY.
- Legality checks, applied at acceptance:
  - Hsize > 010: illegal.
  - Half-word access with Haddr[0]=1: illegal.
  - Word access with Haddr[1:0]!=00: illegal.
  - Offset >= MEM_DEPTH*4: illegal.
  - Any illegal access goes to ERR1.
- States:
  - IDLE: Hready_out=1, Hresp=0.
  - WAIT: Hready_out=0, Hresp=0. A counter loads WAIT_STATES-1 at acceptance and decrements each cycle. Move to DONE when it reaches 0.
  - DONE: Hready_out=1, Hresp=0. This is the final data-phase cycle.
  - ERR1: Hready_out=0, Hresp=1. Always moves to ERR2.
  - ERR2: Hready_out=1, Hresp=1.
- Legal-access transitions: go to WAIT if WAIT_STATES>0, else directly to DONE.
- Leaving DONE or ERR2: go to IDLE, unless a new address phase is accepted in the same cycle (pipelined). A new legal access goes to WAIT/DONE; a new illegal access goes to ERR1.
- During WAIT and ERR1, Hready is low system-wide, so no new address is accepted.
- Write:
  - Hwdata is sampled at the edge ending the DONE cycle.
  - Byte lanes are written per Hsize and captured Haddr[1:0], little-endian:
    - byte: lane = addr[1:0];
    - half: lanes {addr[1],0} and {addr[1],1};
    - word: all four lanes.
  - Unselected bytes are unchanged. ERROR transfers never write.
- Read:
  - Hrdata = mem[captured word index] only while in DONE with a captured read. It is 0 in all other states.
  - The whole word is returned regardless of Hsize.
- Write followed by read of the same word, back-to-back: the read's data phase starts after the write edge, so it returns the new data.
- Hsel deasserting during a data phase does not abort it; the captured transfer completes.
- Reset mid-WAIT: the transfer is abandoned and memory is unchanged.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ;
  - HSIZE_BYTE/HALF/WORD;
  - HRESP_OKAY=0 and HRESP_ERROR=1;
  - the slave state encoding IDLE/WAIT/DONE/ERR1/ERR2.
- One sub-module: ahb_byte_lane_decode, combinational (Hsize, addr[1:0]) -> 4-bit lane enable plus a misaligned flag. It is reused by future slaves.

Test Plan:
- Hresetn low for 2 cycles, then high -> Hready_out=1, Hresp=0, Hrdata=0; IDLE transfers with Hsel=1 -> zero-wait OKAY.
- WAIT_STATES=1: word write 0xDEADBEEF to 0x010, then word read 0x010 -> Hready_out low exactly 1 cycle per transfer, Hrdata=0xDEADBEEF in DONE, Hresp=0.
- Word write 0x00000000 to 0x020, byte write 0x11 to 0x021, half write 0xBBAA to 0x022, then word read 0x020 -> 0xBBAA1100.
- Word read at 0x400 and word read at 0x006 -> each gives Hready_out=0/Hresp=1, then Hready_out=1/Hresp=1; the next legal read returns correct data with OKAY.
- WAIT_STATES=0: pipelined write 0x12345678 to 0x004 followed immediately by a read of 0x004 -> read returns 0x12345678, Hready_out never low.
- Reset asserted during the WAIT cycle of a write of 0xCAFEF00D to 0x008 (old value 0x0) -> after reset, read 0x008 returns 0x00000000 and outputs are at their reset values.
